// File: rtl/matmul_tile_sequencer.sv
// matmul_tile_sequencer
// Sequences a tiled matrix multiply C = A x B over the systolic/accumulator
// core. For every output tile (row-major order) it walks the inner dimension
// in K_STEPS passes. For each pass it presents the RAM block addresses and
// restarts the core. It then captures the accumulated tile into a one-entry
// output buffer with a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a full multiply (sampled only when idle)
//   systolic_finish   core finished the current pass
//   accumulator_done  core accumulated all passes of the current tile
//   core_out          core result word
//   counter_A/B       RAM block addresses for the A and B operands
//   core_rst_n        active-low restart of the systolic core
//   reset_acc         clear the accumulator for a new tile
//   out_data/row/col  captured tile result and its tile coordinates
//   out_last          captured tile is the final one
//   out_valid/ready   output handshake
//   busy, done        operation in progress / one-cycle completion pulse
//   err               sticky protocol error, cleared by an accepted start
module matmul_tile_sequencer #(
  parameter int WIDTH           = 16,
  parameter int CHUNK_SIZE      = 4,
  parameter int BLOCK_SIZE      = 2,
  parameter int INNER_DIMENSION = 4,
  parameter int ROW_SIZE_MAT_A  = 6,
  parameter int COL_SIZE_MAT_B  = 6,
  parameter int ADDR_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        systolic_finish,
  input  logic                        accumulator_done,
  input  logic [WIDTH*CHUNK_SIZE-1:0] core_out,
  output logic [ADDR_WIDTH-1:0]       counter_A,
  output logic [ADDR_WIDTH-1:0]       counter_B,
  output logic                        core_rst_n,
  output logic                        reset_acc,
  output logic [WIDTH*CHUNK_SIZE-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [15:0]                 out_row,
  output logic [15:0]                 out_col,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int K_STEPS   = INNER_DIMENSION / BLOCK_SIZE;
  localparam int TILE_ROWS = ROW_SIZE_MAT_A / BLOCK_SIZE;
  localparam int TILE_COLS = COL_SIZE_MAT_B / BLOCK_SIZE;

  localparam logic [15:0] K_LAST   = 16'(K_STEPS - 1);
  localparam logic [15:0] ROW_LAST = 16'(TILE_ROWS - 1);
  localparam logic [15:0] COL_LAST = 16'(TILE_COLS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    WAIT_ACC,
    ADVANCE,
    DONE
  } state_t;

  state_t      state;
  logic [15:0] k;
  logic [15:0] tile_row;
  logic [15:0] tile_col;
  logic [15:0] next_row;
  logic [15:0] next_col;
  logic        last_pass;
  logic        last_tile;
  logic        drain;
  logic        load_hold;
  logic        capture;
  logic        protocol_err;

  // Block address of pass 'step' for tile index 'tile' along one operand.
  function automatic logic [ADDR_WIDTH-1:0] block_addr(input logic [15:0] step,
                                                       input logic [15:0] tile);
    logic [31:0] sum;
    sum = 32'(step) + 32'(K_STEPS) * 32'(tile);
    return sum[ADDR_WIDTH-1:0];
  endfunction

  always_comb begin
    last_pass = (k == K_LAST);
    last_tile = (tile_row == ROW_LAST) && (tile_col == COL_LAST);
    drain     = out_valid && out_ready;
    // Before the last pass of a tile the buffer must be free (or freeing
    // now), otherwise the coming result would have nowhere to go.
    load_hold = last_pass && out_valid && !out_ready;
    capture   = ((state == RUN) && systolic_finish && last_pass && accumulator_done) ||
                ((state == WAIT_ACC) && accumulator_done);

    if (tile_col == COL_LAST) begin
      next_col = 16'd0;
      next_row = tile_row + 16'd1;
    end else begin
      next_col = tile_col + 16'd1;
      next_row = tile_row;
    end

    protocol_err = 1'b0;
    if (accumulator_done &&
        !(((state == RUN) && last_pass) || (state == WAIT_ACC)))
      protocol_err = 1'b1;
    if (systolic_finish &&
        ((state == IDLE) || (state == LOAD) || (state == WAIT_ACC) || (state == DONE)))
      protocol_err = 1'b1;
  end

  // Single state machine; every output is a register. The output buffer
  // update comes before the state case so a capture overrides a drain in
  // the same cycle, and the start-time clear of err overrides a new error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= 16'd0;
      tile_row   <= 16'd0;
      tile_col   <= 16'd0;
      counter_A  <= '0;
      counter_B  <= '0;
      core_rst_n <= 1'b0;
      reset_acc  <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_row    <= 16'd0;
      out_col    <= 16'd0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (protocol_err) err <= 1'b1;

      if (drain) out_valid <= 1'b0;
      if (capture) begin
        out_data  <= core_out;
        out_row   <= tile_row;
        out_col   <= tile_col;
        out_last  <= last_tile;
        out_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            k         <= 16'd0;
            tile_row  <= 16'd0;
            tile_col  <= 16'd0;
            counter_A <= '0;
            counter_B <= '0;
            reset_acc <= 1'b1;
            busy      <= 1'b1;
            err       <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (!load_hold) begin
            core_rst_n <= 1'b1;
            reset_acc  <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (systolic_finish) begin
            core_rst_n <= 1'b0;
            if (!last_pass) begin
              k         <= k + 16'd1;
              counter_A <= block_addr(k + 16'd1, tile_row);
              counter_B <= block_addr(k + 16'd1, tile_col);
              state     <= LOAD;
            end else if (accumulator_done) begin
              state <= ADVANCE;
            end else begin
              state <= WAIT_ACC;
            end
          end
        end
        WAIT_ACC: begin
          if (accumulator_done) state <= ADVANCE;
        end
        ADVANCE: begin
          k <= 16'd0;
          if (last_tile) begin
            tile_row <= 16'd0;
            tile_col <= 16'd0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            tile_row  <= next_row;
            tile_col  <= next_col;
            counter_A <= block_addr(16'd0, next_row);
            counter_B <= block_addr(16'd0, next_col);
            reset_acc <= 1'b1;
            state     <= LOAD;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// tb_matmul_tile_sequencer
// Drives two sequencer instances: the default 6x4x6 configuration (K_STEPS=2,
// 3x3 tiles) and a 4x6x8 configuration (K_STEPS=3, 2x4 tiles). A small core
// model raises systolic_finish in the fifth cycle the core is out of reset,
// and accumulator_done one cycle later after the last pass. In same-cycle mode
// it raises accumulator_done together with the final systolic_finish instead.
// core_out encodes {C0DE, pass count, first A address, first B address} so
// each captured word identifies the tile it came from.
`timescale 1ns/1ps
module tb_matmul_tile_sequencer;

  typedef struct {
    int          inst;
    logic [15:0] row;
    logic [15:0] col;
    logic        last;
    logic [63:0] data;
    int          cyc;
  } xfer_t;

  typedef struct {
    int          inst;
    logic [15:0] a;
    logic [15:0] b;
    logic        racc;
  } pass_t;

  logic        clk;
  logic        rst_n;
  logic        start_s [2];
  logic        sfin    [2];
  logic        accd    [2];
  logic        ordy    [2];
  logic [63:0] cout    [2];
  logic [63:0] odata   [2];
  logic [15:0] ca      [2];
  logic [15:0] cb      [2];
  logic [15:0] orow    [2];
  logic [15:0] ocol    [2];
  logic        crn     [2];
  logic        racc    [2];
  logic        ov      [2];
  logic        olast   [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        err_s   [2];

  int          checks;
  int          errors;
  int          cyc = 0;
  int          run_cnt  [2];
  int          passes   [2];
  int          done_cnt [2];
  logic        acc_pend [2];
  logic        prev_racc[2];
  logic        spurious [2];
  logic [15:0] a0 [2];
  logic [15:0] b0 [2];
  logic        same_mode;
  xfer_t       xq[$];
  pass_t       pq[$];
  xfer_t       xrec;
  pass_t       prec;

  matmul_tile_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]),
    .systolic_finish(sfin[0]), .accumulator_done(accd[0]), .core_out(cout[0]),
    .counter_A(ca[0]), .counter_B(cb[0]), .core_rst_n(crn[0]), .reset_acc(racc[0]),
    .out_data(odata[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_row(orow[0]), .out_col(ocol[0]), .out_last(olast[0]),
    .busy(busy_s[0]), .done(done_s[0]), .err(err_s[0])
  );

  matmul_tile_sequencer #(
    .INNER_DIMENSION(6), .ROW_SIZE_MAT_A(4), .COL_SIZE_MAT_B(8)
  ) u_rect (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]),
    .systolic_finish(sfin[1]), .accumulator_done(accd[1]), .core_out(cout[1]),
    .counter_A(ca[1]), .counter_B(cb[1]), .core_rst_n(crn[1]), .reset_acc(racc[1]),
    .out_data(odata[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_row(orow[1]), .out_col(ocol[1]), .out_last(olast[1]),
    .busy(busy_s[1]), .done(done_s[1]), .err(err_s[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int kof(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  // Core model plus transfer / pass / done monitors, all on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        run_cnt[i]   = 0;
        passes[i]    = 0;
        acc_pend[i]  = 1'b0;
        prev_racc[i] = 1'b0;
        sfin[i]      = 1'b0;
        accd[i]      = 1'b0;
        a0[i]        = 16'd0;
        b0[i]        = 16'd0;
        cout[i]      = 64'd0;
      end else begin
        accd[i]     = acc_pend[i];
        acc_pend[i] = 1'b0;
        if (racc[i]) begin
          passes[i] = 0;
          a0[i]     = ca[i];
          b0[i]     = cb[i];
        end
        if (crn[i]) run_cnt[i]++;
        else        run_cnt[i] = 0;
        if (run_cnt[i] == 1) begin
          prec.inst = i;
          prec.a    = ca[i];
          prec.b    = cb[i];
          prec.racc = prev_racc[i];
          pq.push_back(prec);
        end
        sfin[i] = (run_cnt[i] == 5);
        if (sfin[i]) begin
          passes[i]++;
          if (passes[i] == kof(i)) begin
            if (same_mode) accd[i] = 1'b1;
            else           acc_pend[i] = 1'b1;
          end
        end
        if (spurious[i]) accd[i] = 1'b1;
        prev_racc[i] = racc[i];
        cout[i] = {16'hC0DE, 16'(passes[i]), a0[i], b0[i]};
        if (ov[i] && ordy[i]) begin
          xrec.inst = i;
          xrec.row  = orow[i];
          xrec.col  = ocol[i];
          xrec.last = olast[i];
          xrec.data = odata[i];
          xrec.cyc  = cyc;
          xq.push_back(xrec);
        end
        if (done_s[i]) done_cnt[i]++;
      end
    end
  end

  function automatic int n_xfers(input int i);
    int n;
    n = 0;
    foreach (xq[j]) if (xq[j].inst == i) n++;
    return n;
  endfunction

  function automatic int n_passes(input int i);
    int n;
    n = 0;
    foreach (pq[j]) if (pq[j].inst == i) n++;
    return n;
  endfunction

  // Number of leading transfers that follow the expected row-major sequence.
  function automatic int ordered_tiles(input int i, input int tcols, input int kk,
                                       input int ntiles);
    int n;
    int r;
    int c;
    bit broken;
    n = 0;
    broken = 1'b0;
    foreach (xq[j]) begin
      if (xq[j].inst == i && !broken) begin
        r = n / tcols;
        c = n % tcols;
        if (n < ntiles && xq[j].row == 16'(r) && xq[j].col == 16'(c) &&
            xq[j].last == (n == ntiles - 1) &&
            xq[j].data == {16'hC0DE, 16'(kk), 16'(kk * r), 16'(kk * c)})
          n++;
        else
          broken = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic pass_t pass_at(input int i, input int idx);
    pass_t r;
    int    n;
    bit    found;
    r.inst = -1;
    r.a    = 16'hFFFF;
    r.b    = 16'hFFFF;
    r.racc = 1'b0;
    n      = 0;
    found  = 1'b0;
    foreach (pq[j]) begin
      if (pq[j].inst == i && !found) begin
        if (n == idx) begin
          r     = pq[j];
          found = 1'b1;
        end
        n++;
      end
    end
    return r;
  endfunction

  function automatic int period(input int i);
    int t[$];
    foreach (xq[j]) if (xq[j].inst == i) t.push_back(xq[j].cyc);
    if (t.size() < 2) return -1;
    return t[1] - t[0];
  endfunction

  task automatic clear_logs(input int i);
    xq.delete();
    pq.delete();
    done_cnt[i] = 0;
  endtask

  task automatic do_start(input int i);
    @(posedge clk); #1;
    start_s[i] = 1'b1;
    @(posedge clk); #1;
    start_s[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (done_s[i]) ok = 1'b1;
    end
  endtask

  task automatic wait_valid(input int i, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (ov[i]) ok = 1'b1;
    end
  endtask

  task automatic wait_run_at(input int i, input logic [15:0] a, input logic [15:0] b,
                             input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (crn[i] && ca[i] == a && cb[i] == b) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({ca[i], cb[i]} !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset_addr[%0d]: got A=%0d B=%0d expected 0 0", i, ca[i], cb[i]);
      end
      checks++;
      if ({crn[i], racc[i], ov[i], olast[i], busy_s[i], done_s[i], err_s[i]} !== 7'd0) begin
        errors++;
        $display("[TB] FAIL reset_flags[%0d]: got core_rst_n=%b reset_acc=%b valid=%b last=%b busy=%b done=%b err=%b expected all 0",
                 i, crn[i], racc[i], ov[i], olast[i], busy_s[i], done_s[i], err_s[i]);
      end
      checks++;
      if ({odata[i], orow[i], ocol[i]} !== 96'd0) begin
        errors++;
        $display("[TB] FAIL reset_out[%0d]: got data=%h row=%0d col=%0d expected 0", i, odata[i], orow[i], ocol[i]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_full_sequence;
    bit ok;
    pass_t p;
    clear_logs(0);
    ordy[0] = 1'b1;
    do_start(0);
    checks++;
    if (busy_s[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_after_start: got %b expected 1", busy_s[0]);
    end
    // A second start while busy must be ignored.
    repeat (20) @(posedge clk);
    #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    wait_done(0, 1000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL full_done_timeout: got no done expected done within 1000 cycles");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n_xfers(0) !== 9 || ordered_tiles(0, 3, 2, 9) !== 9) begin
      errors++;
      $display("[TB] FAIL full_tiles: got %0d transfers %0d in order expected 9 9", n_xfers(0), ordered_tiles(0, 3, 2, 9));
    end
    checks++;
    if (done_cnt[0] !== 1 || err_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_status: got done_cnt=%0d err=%b busy=%b expected 1 0 0", done_cnt[0], err_s[0], busy_s[0]);
    end
    checks++;
    if (period(0) !== 14) begin
      errors++;
      $display("[TB] FAIL full_period: got %0d expected 14", period(0));
    end
    checks++;
    if (n_passes(0) !== 18) begin
      errors++;
      $display("[TB] FAIL full_passes: got %0d expected 18", n_passes(0));
    end
    // Tile (1,2) is the sixth tile: passes 10 and 11.
    p = pass_at(0, 10);
    checks++;
    if (p.a !== 16'd2 || p.b !== 16'd4 || p.racc !== 1'b1) begin
      errors++;
      $display("[TB] FAIL addr_t12_k0: got A=%0d B=%0d racc=%b expected 2 4 1", p.a, p.b, p.racc);
    end
    p = pass_at(0, 11);
    checks++;
    if (p.a !== 16'd3 || p.b !== 16'd5 || p.racc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL addr_t12_k1: got A=%0d B=%0d racc=%b expected 3 5 0", p.a, p.b, p.racc);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    bit stable;
    logic [63:0] saved;
    clear_logs(0);
    ordy[0] = 1'b0;
    do_start(0);
    wait_valid(0, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL bp_first_valid: got no out_valid expected within 200 cycles");
    end
    saved = odata[0];
    checks++;
    if (saved !== {16'hC0DE, 16'd2, 16'd0, 16'd0}) begin
      errors++;
      $display("[TB] FAIL bp_first_data: got %h expected c0de000200000000", saved);
    end
    stable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ov[0] !== 1'b1 || odata[0] !== saved || orow[0] !== 16'd0 ||
          ocol[0] !== 16'd0 || olast[0] !== 1'b0)
        stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_hold_stable: got unstable output expected stable for 40 cycles");
    end
    checks++;
    if (crn[0] !== 1'b0 || ca[0] !== 16'd1 || cb[0] !== 16'd3 || racc[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_load_gate: got core_rst_n=%b A=%0d B=%0d racc=%b expected 0 1 3 0", crn[0], ca[0], cb[0], racc[0]);
    end
    checks++;
    if (n_xfers(0) !== 0 || busy_s[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_no_transfer: got %0d transfers busy=%b expected 0 1", n_xfers(0), busy_s[0]);
    end
    @(posedge clk); #1 ordy[0] = 1'b1;
    wait_done(0, 1000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL bp_done_timeout: got no done expected done within 1000 cycles");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n_xfers(0) !== 9 || ordered_tiles(0, 3, 2, 9) !== 9) begin
      errors++;
      $display("[TB] FAIL bp_tiles: got %0d transfers %0d in order expected 9 9", n_xfers(0), ordered_tiles(0, 3, 2, 9));
    end
    checks++;
    if (n_passes(0) !== 18 || err_s[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_passes: got %0d passes err=%b expected 18 0", n_passes(0), err_s[0]);
    end
  endtask

  task automatic test_same_cycle_acc;
    bit ok;
    clear_logs(0);
    same_mode = 1'b1;
    ordy[0] = 1'b1;
    do_start(0);
    wait_done(0, 1000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL same_done_timeout: got no done expected done within 1000 cycles");
    end
    repeat (3) @(negedge clk);
    same_mode = 1'b0;
    checks++;
    if (n_xfers(0) !== 9 || ordered_tiles(0, 3, 2, 9) !== 9) begin
      errors++;
      $display("[TB] FAIL same_tiles: got %0d transfers %0d in order expected 9 9", n_xfers(0), ordered_tiles(0, 3, 2, 9));
    end
    checks++;
    if (period(0) !== 13) begin
      errors++;
      $display("[TB] FAIL same_period: got %0d expected 13", period(0));
    end
    checks++;
    if (err_s[0] !== 1'b0 || done_cnt[0] !== 1) begin
      errors++;
      $display("[TB] FAIL same_status: got err=%b done_cnt=%0d expected 0 1", err_s[0], done_cnt[0]);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    clear_logs(0);
    ordy[0] = 1'b1;
    do_start(0);
    wait_run_at(0, 16'd2, 16'd2, 500, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL rst_reach_t11: got tile (1,1) not reached expected within 500 cycles");
    end
    @(posedge clk); #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({ca[0], cb[0], crn[0], racc[0], ov[0], olast[0], busy_s[0], done_s[0], err_s[0]} !== 39'd0 ||
        {odata[0], orow[0], ocol[0]} !== 96'd0) begin
      errors++;
      $display("[TB] FAIL rst_mid_outputs: got A=%0d B=%0d crn=%b valid=%b busy=%b data=%h expected all 0",
               ca[0], cb[0], crn[0], ov[0], busy_s[0], odata[0]);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    clear_logs(0);
    do_start(0);
    wait_done(0, 1000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL rst_done_timeout: got no done expected done within 1000 cycles");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n_xfers(0) !== 9 || ordered_tiles(0, 3, 2, 9) !== 9 || err_s[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_rerun_tiles: got %0d transfers %0d in order err=%b expected 9 9 0",
               n_xfers(0), ordered_tiles(0, 3, 2, 9), err_s[0]);
    end
  endtask

  task automatic test_rect_config;
    bit ok;
    pass_t p;
    clear_logs(1);
    ordy[1] = 1'b1;
    do_start(1);
    wait_done(1, 2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL rect_done_timeout: got no done expected done within 2000 cycles");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n_xfers(1) !== 8 || ordered_tiles(1, 4, 3, 8) !== 8) begin
      errors++;
      $display("[TB] FAIL rect_tiles: got %0d transfers %0d in order expected 8 8", n_xfers(1), ordered_tiles(1, 4, 3, 8));
    end
    checks++;
    if (n_passes(1) !== 24 || err_s[1] !== 1'b0 || done_cnt[1] !== 1) begin
      errors++;
      $display("[TB] FAIL rect_status: got passes=%0d err=%b done_cnt=%0d expected 24 0 1", n_passes(1), err_s[1], done_cnt[1]);
    end
    // Tile (1,3) is the eighth tile: passes 21, 22, 23.
    p = pass_at(1, 21);
    checks++;
    if (p.a !== 16'd3 || p.b !== 16'd9 || p.racc !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rect_t13_k0: got A=%0d B=%0d racc=%b expected 3 9 1", p.a, p.b, p.racc);
    end
    p = pass_at(1, 22);
    checks++;
    if (p.a !== 16'd4 || p.b !== 16'd10 || p.racc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rect_t13_k1: got A=%0d B=%0d racc=%b expected 4 10 0", p.a, p.b, p.racc);
    end
    p = pass_at(1, 23);
    checks++;
    if (p.a !== 16'd5 || p.b !== 16'd11 || p.racc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rect_t13_k2: got A=%0d B=%0d racc=%b expected 5 11 0", p.a, p.b, p.racc);
    end
  endtask

  task automatic test_spurious_acc;
    bit ok;
    clear_logs(1);
    ordy[1] = 1'b1;
    do_start(1);
    wait_run_at(1, 16'd0, 16'd0, 300, ok);
    checks++;
    if (!ok || err_s[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL spur_pre: got reached=%0d err=%b expected 1 0", ok, err_s[1]);
    end
    @(posedge clk); #1 spurious[1] = 1'b1;
    @(posedge clk); #1 spurious[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (err_s[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL spur_err_set: got %b expected 1", err_s[1]);
    end
    wait_done(1, 2000, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || err_s[1] !== 1'b1 || n_xfers(1) !== 8) begin
      errors++;
      $display("[TB] FAIL spur_sticky: got done=%0d err=%b transfers=%0d expected 1 1 8", ok, err_s[1], n_xfers(1));
    end
    do_start(1);
    checks++;
    if (err_s[1] !== 1'b0 || busy_s[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL spur_clear_on_start: got err=%b busy=%b expected 0 1", err_s[1], busy_s[1]);
    end
    wait_done(1, 2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL spur_rerun_timeout: got no done expected done within 2000 cycles");
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    same_mode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i]  = 1'b0;
      ordy[i]     = 1'b1;
      spurious[i] = 1'b0;
      done_cnt[i] = 0;
    end
    test_reset();
    test_full_sequence();
    test_backpressure();
    test_same_cycle_acc();
    test_reset_mid();
    test_rect_config();
    test_spurious_acc();
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
